// File: rtl/idct8_2d_sequencer_if.sv
// idct8_2d_sequencer_if: coefficient, datapath and result bus of the 2-D IDCT sequencer
interface idct8_2d_sequencer_if #(parameter int W = 25);
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] in_data;
  logic [8*W-1:0] idct_in;
  logic [8*W-1:0] idct_out;
  logic           out_valid;
  logic [8*W-1:0] out_data;
  logic [2:0]     out_col;
  logic           out_last;
  modport master (input in_valid, in_data, idct_out,
                  output in_ready, idct_in, out_valid, out_data, out_col, out_last);
  modport slave  (output in_valid, in_data, idct_out,
                  input in_ready, idct_in, out_valid, out_data, out_col, out_last);
endinterface

// File: rtl/idct8_2d_sequencer.sv
// idct8_2d_sequencer: row/column pass sequencer sharing one 1-D IDCT8 datapath via a transpose buffer
module idct8_2d_sequencer #(
  parameter int IDCT_LAT = 4,
  parameter int W        = 25
) (
  input logic                  clk,
  input logic                  reset,
  idct8_2d_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ROW_IN, ROW_WAIT, COL_ISSUE} state_t;
  typedef struct packed {logic valid; logic col; logic [2:0] idx;} tag_t;
  state_t         state_q, state_d;
  logic [2:0]     row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
  logic           in_ready_q, in_ready_d;
  logic [8*W-1:0] idct_in_q, idct_in_d;
  tag_t           tag_q [0:IDCT_LAT];
  tag_t           tag_d [0:IDCT_LAT];
  logic [W-1:0]   buf_q [8][8];
  logic [W-1:0]   buf_d [8][8];
  logic           out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [8*W-1:0] out_data_q, out_data_d;
  logic [2:0]     out_col_q, out_col_d;
  logic           hs, row_wr, col_rd, last_row, issue;
  tag_t           tag_out;
  logic [8*W-1:0] col_vec;
  // tag_q[0] travels with idct_in; tag_q[IDCT_LAT] lines up with idct_out.
  // Column 0 is issued on the same edge row 7 lands, so a row being written is forwarded into the column read.
  always_comb begin
    hs       = bus.in_valid && in_ready_q;
    tag_out  = tag_q[IDCT_LAT];
    row_wr   = tag_out.valid && !tag_out.col;
    col_rd   = tag_out.valid && tag_out.col;
    last_row = row_wr && tag_out.idx == 3'd7;
    issue    = (state_q == ROW_WAIT && last_row) || (state_q == COL_ISSUE && col_cnt_q != 3'd0);
    for (int r = 0; r < 8; r++)
      col_vec[W*r +: W] = (row_wr && tag_out.idx == 3'(r)) ? bus.idct_out[W*col_cnt_q +: W] : buf_q[r][col_cnt_q];
    idct_in_d = hs ? bus.in_data : issue ? col_vec : '0;
    tag_d[0]  = hs ? {1'b1, 1'b0, row_cnt_q} : issue ? {1'b1, 1'b1, col_cnt_q} : '0;
    for (int i = 1; i <= IDCT_LAT; i++) tag_d[i] = tag_q[i-1];
    row_cnt_d = hs ? row_cnt_q + 3'd1 : row_cnt_q;
    col_cnt_d = issue ? col_cnt_q + 3'd1 : col_cnt_q;
    state_d   = (state_q == IDLE && hs) ? ROW_IN :
                (state_q == ROW_IN && hs && row_cnt_q == 3'd7) ? ROW_WAIT :
                (state_q == ROW_WAIT && last_row) ? COL_ISSUE :
                (state_q == COL_ISSUE && col_cnt_q == 3'd0) ? IDLE : state_q;
    in_ready_d  = state_d == IDLE || state_d == ROW_IN;
    out_valid_d = col_rd;
    out_last_d  = col_rd && tag_out.idx == 3'd7;
    out_data_d  = col_rd ? bus.idct_out : out_data_q;
    out_col_d   = col_rd ? tag_out.idx : out_col_q;
    buf_d = buf_q;
    if (row_wr)
      for (int k = 0; k < 8; k++) buf_d[tag_out.idx][k] = bus.idct_out[W*k +: W];
  end
  // Control state, tag pipeline and registered outputs; a reset discards any block in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      idct_in_q   <= '0;
      for (int i = 0; i <= IDCT_LAT; i++) tag_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      in_ready_q  <= in_ready_d;
      idct_in_q   <= idct_in_d;
      for (int i = 0; i <= IDCT_LAT; i++) tag_q[i] <= tag_d[i];
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
    end
  end
  // Transpose buffer keeps its contents across reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.idct_in   = idct_in_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_last  = out_last_q;
endmodule
